// File: rtl/stopwatch_ctrl_if.sv
// Key/switch inputs and display/status outputs of the stopwatch controller.
// The master side drives keys and lap switch; the controller is the slave.
interface stopwatch_ctrl_if;
  logic        key_start_n;
  logic        key_clear_n;
  logic        lap_en;
  logic        run;
  logic        tick;
  logic        overflow;
  logic [23:0] digits;

  modport master (
    output key_start_n, key_clear_n, lap_en,
    input  run, tick, overflow, digits
  );

  modport slave (
    input  key_start_n, key_clear_n, lap_en,
    output run, tick, overflow, digits
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear controller for a MM:SS.cc stopwatch: debounced keys,
// centisecond prescaler, saturating 6-digit BCD counter and lap snapshot.
module stopwatch_ctrl #(
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          TICK_HZ      = 100,
  parameter int          DEBOUNCE_CYC = 1_000_000,
  parameter logic [23:0] INIT_COUNT   = 24'h000000
) (
  input logic            MAX10_CLK1_50,
  input logic            reset,
  stopwatch_ctrl_if.slave sw
);

  localparam int PRESC_MAX = CLK_HZ / TICK_HZ - 1;
  localparam int PW = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(PRESC_MAX);
  localparam logic [DW-1:0] DEB_TERM   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [23:0]   COUNT_MAX  = 24'h595999;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;

  // One-step BCD increment; each digit wraps at 9, or at 5 for the tens of seconds/minutes.
  function automatic logic [23:0] bcd_inc(input logic [23:0] c);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  lim;
    r     = c;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (carry) begin
        if (r[i*4 +: 4] >= lim) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Stage p0/p1: two-flop synchronizer for {lap_en, key_clear_n, key_start_n}
  logic [2:0] sync_p0, sync_p1;

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      sync_p0 <= 3'b011;
      sync_p1 <= 3'b011;
    end else begin
      sync_p0 <= {sw.lap_en, sw.key_clear_n, sw.key_start_n};
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: the level flips on the last of DEBOUNCE_CYC consecutive differing samples
  logic [1:0]    db_lvl;
  logic [DW-1:0] db_cnt [2];
  logic [1:0]    press;

  always_comb begin
    press = 2'b00;
    for (int i = 0; i < 2; i++)
      press[i] = db_lvl[i] & ~sync_p1[i] & (db_cnt[i] == DEB_TERM);
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        db_lvl[i] <= 1'b1;
        db_cnt[i] <= '0;
      end else if (sync_p1[i] == db_lvl[i]) begin
        db_cnt[i] <= '0;
      end else if (db_cnt[i] == DEB_TERM) begin
        db_lvl[i] <= sync_p1[i];
        db_cnt[i] <= '0;
      end else begin
        db_cnt[i] <= db_cnt[i] + DW'(1);
      end
    end
  end

  logic p_start, p_clear, lap_en_s;
  assign p_start  = press[0];
  assign p_clear  = press[1];
  assign lap_en_s = sync_p1[2];

  // Control FSM, prescaler and BCD counter
  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [23:0]   count, snap;
  logic          ovf, show_snap;
  logic          active, tick_w, sat;

  assign active = (state == S_RUN) || (state == S_LAP);
  assign tick_w = active && (presc == PRESC_TERM);
  assign sat    = tick_w && (count == COUNT_MAX);

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state     <= S_IDLE;
      presc     <= '0;
      count     <= INIT_COUNT;
      ovf       <= 1'b0;
      show_snap <= 1'b0;
    end else begin
      if (active)
        presc <= (presc == PRESC_TERM) ? '0 : presc + PW'(1);
      if (tick_w && !sat)
        count <= bcd_inc(count);

      // Saturation beats keys; clear beats start when both arrive together.
      if (sat) begin
        state <= S_PAUSE;
        ovf   <= 1'b1;
      end else if (p_clear) begin
        case (state)
          S_RUN: if (lap_en_s) begin
            state     <= S_LAP;
            snap      <= count;
            show_snap <= 1'b1;
          end
          S_LAP: begin
            state     <= S_RUN;
            show_snap <= 1'b0;
          end
          S_PAUSE: begin
            state     <= S_IDLE;
            count     <= 24'h000000;
            presc     <= '0;
            ovf       <= 1'b0;
            show_snap <= 1'b0;
          end
          default: ;
        endcase
      end else if (p_start) begin
        case (state)
          S_IDLE:  state <= S_RUN;
          S_RUN:   state <= S_PAUSE;
          S_LAP:   state <= S_PAUSE;
          S_PAUSE: if (!ovf) begin
            state     <= S_RUN;
            show_snap <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign sw.run      = active;
  assign sw.tick     = tick_w;
  assign sw.overflow = ovf;
  assign sw.digits   = show_snap ? snap : count;

endmodule
